// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Raster timing generator with look-ahead pixel requests and a
//            selectable pixel formatter (RGB565, RGB888, colour bars, solid).
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_SYNC   = 44,
    parameter int H_BACK   = 148,
    parameter int H_DISP   = 1920,
    parameter int H_FRONT  = 88,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 36,
    parameter int V_DISP   = 1080,
    parameter int V_FRONT  = 4,
    parameter int REQ_LEAD = 1,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  fmt_sel,
    input  logic [23:0] pixel_in,
    input  logic [23:0] solid_rgb,
    output logic        data_req,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        frame_start
);

    localparam logic [12:0] c_h_total = 13'(H_SYNC + H_BACK + H_DISP + H_FRONT);
    localparam logic [12:0] c_v_total = 13'(V_SYNC + V_BACK + V_DISP + V_FRONT);
    localparam logic [12:0] c_h_sync  = 13'(H_SYNC);
    localparam logic [12:0] c_v_sync  = 13'(V_SYNC);
    localparam logic [12:0] c_h_act0  = 13'(H_SYNC + H_BACK);
    localparam logic [12:0] c_h_act1  = 13'(H_SYNC + H_BACK + H_DISP);
    localparam logic [12:0] c_v_act0  = 13'(V_SYNC + V_BACK);
    localparam logic [12:0] c_v_act1  = 13'(V_SYNC + V_BACK + V_DISP);
    localparam logic [12:0] c_lead    = 13'(REQ_LEAD);
    localparam bit          c_bars_ok = (H_DISP >= 8);
    localparam logic [12:0] c_bar_w   = 13'((H_DISP >= 8) ? (H_DISP / 8) : 1);

    logic [12:0] r_h_cnt;
    logic [12:0] r_v_cnt;
    logic [1:0]  r_mode;

    logic        w_h_wrap;
    logic        w_v_last;
    logic [12:0] w_h_nxt;
    logic [12:0] w_v_nxt;
    logic [12:0] w_v_inc;
    logic [12:0] w_hl_sum;
    logic [12:0] w_hl;
    logic [12:0] w_vl;
    logic        w_de_d;
    logic        w_req_d;
    logic [12:0] w_col;
    logic [12:0] w_bar_idx;
    logic [23:0] w_bar_rgb;
    logic [23:0] w_fmt_rgb;

    function automatic logic in_active(input logic [12:0] h, input logic [12:0] v);
        return (h >= c_h_act0) && (h < c_h_act1) && (v >= c_v_act0) && (v < c_v_act1);
    endfunction

    // The request position runs REQ_LEAD pixels ahead and may spill into the next line.
    always_comb begin
        w_h_wrap = (r_h_cnt == c_h_total - 13'd1);
        w_v_last = (r_v_cnt == c_v_total - 13'd1);
        w_v_inc  = w_v_last ? 13'd0 : r_v_cnt + 13'd1;
        w_h_nxt  = w_h_wrap ? 13'd0 : r_h_cnt + 13'd1;
        w_v_nxt  = w_h_wrap ? w_v_inc : r_v_cnt;
        w_hl_sum = r_h_cnt + c_lead;
        w_hl     = w_hl_sum;
        w_vl     = r_v_cnt;
        if (w_hl_sum >= c_h_total) begin
            w_hl = w_hl_sum - c_h_total;
            w_vl = w_v_inc;
        end
        w_de_d   = in_active(r_h_cnt, r_v_cnt);
        w_req_d  = in_active(w_hl, w_vl);
    end

    always_comb begin
        w_col     = r_h_cnt - c_h_act0;
        w_bar_idx = w_col / c_bar_w;
        w_bar_rgb = 24'h000000;
        if (c_bars_ok && (w_bar_idx < 13'd8)) begin
            case (3'(w_bar_idx))
                3'd0:    w_bar_rgb = 24'hFFFFFF;
                3'd1:    w_bar_rgb = 24'hFFFF00;
                3'd2:    w_bar_rgb = 24'h00FFFF;
                3'd3:    w_bar_rgb = 24'h00FF00;
                3'd4:    w_bar_rgb = 24'hFF00FF;
                3'd5:    w_bar_rgb = 24'hFF0000;
                3'd6:    w_bar_rgb = 24'h0000FF;
                default: w_bar_rgb = 24'h000000;
            endcase
        end
    end

    always_comb begin
        w_fmt_rgb = 24'h000000;
        case (r_mode)
            2'd0:    w_fmt_rgb = {pixel_in[15:11], 3'b000, pixel_in[10:5], 2'b00,
                                  pixel_in[4:0], 3'b000};
            2'd1:    w_fmt_rgb = pixel_in;
            2'd2:    w_fmt_rgb = w_bar_rgb;
            default: w_fmt_rgb = solid_rgb;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_mode      <= '0;
            data_req    <= 1'b0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            video_hs    <= ~SYNC_POL;
            video_vs    <= ~SYNC_POL;
            video_de    <= 1'b0;
            video_rgb   <= '0;
            frame_start <= 1'b0;
        end else begin
            r_h_cnt     <= w_h_nxt;
            r_v_cnt     <= w_v_nxt;
            // Mode only changes on the frame boundary so a frame is never mixed.
            if ((r_h_cnt == 13'd0) && (r_v_cnt == 13'd0)) begin
                r_mode <= fmt_sel;
            end
            data_req    <= w_req_d;
            pixel_xpos  <= w_req_d ? 11'(w_hl - c_h_act0) : 11'd0;
            pixel_ypos  <= w_req_d ? 11'(w_vl - c_v_act0) : 11'd0;
            video_hs    <= (r_h_cnt < c_h_sync) ? SYNC_POL : ~SYNC_POL;
            video_vs    <= (r_v_cnt < c_v_sync) ? SYNC_POL : ~SYNC_POL;
            video_de    <= w_de_d;
            video_rgb   <= w_de_d ? w_fmt_rgb : 24'h000000;
            frame_start <= (r_h_cnt == 13'd0) && (r_v_cnt == 13'd0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Purpose  : Self-checking bench; a frame-position model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int HS = 4, HB = 4, HD = 16, HF = 4;
    localparam int VS = 2, VB = 2, VD = 4, VF = 2;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FT = HT * VT;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic [1:0]  fmt_sel   = 2'd1;
    logic [23:0] pixel_in  = 24'h0;
    logic [23:0] solid_rgb = 24'h0;

    logic        d1_req, d1_hs, d1_vs, d1_de, d1_fs;
    logic [10:0] d1_x, d1_y;
    logic [23:0] d1_rgb;
    logic        d3_req, d3_hs, d3_vs, d3_de, d3_fs;
    logic [10:0] d3_x, d3_y;
    logic [23:0] d3_rgb;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;
    logic [1:0] model_mode = 2'd0;
    int de_cnt1, req_cnt1, de_cnt3, req_cnt3;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    video_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .REQ_LEAD(1), .SYNC_POL(1'b1)
    ) dut1 (
        .pixel_clk(clk), .sys_rst_n(rst_n), .fmt_sel(fmt_sel),
        .pixel_in(pixel_in), .solid_rgb(solid_rgb),
        .data_req(d1_req), .pixel_xpos(d1_x), .pixel_ypos(d1_y),
        .video_hs(d1_hs), .video_vs(d1_vs), .video_de(d1_de),
        .video_rgb(d1_rgb), .frame_start(d1_fs)
    );

    video_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .REQ_LEAD(3), .SYNC_POL(1'b1)
    ) dut3 (
        .pixel_clk(clk), .sys_rst_n(rst_n), .fmt_sel(fmt_sel),
        .pixel_in(pixel_in), .solid_rgb(solid_rgb),
        .data_req(d3_req), .pixel_xpos(d3_x), .pixel_ypos(d3_y),
        .video_hs(d3_hs), .video_vs(d3_vs), .video_de(d3_de),
        .video_rgb(d3_rgb), .frame_start(d3_fs)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h framepos=%0d", tag, obs, exp, pos);
        end
    endtask

    function automatic bit in_active(input int h, input int v);
        return (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);
    endfunction

    function automatic logic [23:0] ref_pixel(input logic [1:0] m, input logic [23:0] p,
                                              input logic [23:0] s, input int col);
        int idx;
        idx = col / (HD / 8);
        case (m)
            2'd0:    return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
            2'd1:    return p;
            2'd2:    return (idx < 8) ? bars[idx] : 24'h000000;
            default: return s;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_d1_outs"}, {15'd0, d1_req, d1_hs, d1_vs, d1_de, d1_fs, 4'd0}, 24'd0);
        check({tag, "_d1_x"}, 24'(d1_x), 24'd0);
        check({tag, "_d1_y"}, 24'(d1_y), 24'd0);
        check({tag, "_d1_rgb"}, d1_rgb, 24'd0);
        check({tag, "_d3_outs"}, {15'd0, d3_req, d3_hs, d3_vs, d3_de, d3_fs, 4'd0}, 24'd0);
        check({tag, "_d3_rgb"}, d3_rgb, 24'd0);
    endtask

    // One clock: check everything against the frame-position model, then drive new inputs.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            int p, h, v, q1, q3;
            bit de_e, r1_e, r3_e;
            logic [23:0] rgb_e;
            @(posedge clk);
            #1;
            p = pos;
            h = p % HT;
            v = p / HT;
            if (p == 0) begin
                model_mode = fmt_sel;
                de_cnt1 = 0; req_cnt1 = 0; de_cnt3 = 0; req_cnt3 = 0;
            end
            de_e  = in_active(h, v);
            rgb_e = de_e ? ref_pixel(model_mode, pixel_in, solid_rgb, h - HS - HB) : 24'h0;
            q1 = (p + 1) % FT;
            q3 = (p + 3) % FT;
            r1_e = in_active(q1 % HT, q1 / HT);
            r3_e = in_active(q3 % HT, q3 / HT);

            check("d1_hs", 24'(d1_hs), 24'(h < HS));
            check("d1_vs", 24'(d1_vs), 24'(v < VS));
            check("d1_frame_start", 24'(d1_fs), 24'(p == 0));
            check("d1_de", 24'(d1_de), 24'(de_e));
            check("d1_rgb", d1_rgb, rgb_e);
            check("d1_req", 24'(d1_req), 24'(r1_e));
            check("d1_xpos", 24'(d1_x), r1_e ? 24'(q1 % HT - HS - HB) : 24'd0);
            check("d1_ypos", 24'(d1_y), r1_e ? 24'(q1 / HT - VS - VB) : 24'd0);
            check("d3_hs_vs_fs", {21'd0, d3_hs, d3_vs, d3_fs},
                  {21'd0, 1'(h < HS), 1'(v < VS), 1'(p == 0)});
            check("d3_de", 24'(d3_de), 24'(de_e));
            check("d3_rgb", d3_rgb, rgb_e);
            check("d3_req", 24'(d3_req), 24'(r3_e));
            check("d3_xpos", 24'(d3_x), r3_e ? 24'(q3 % HT - HS - HB) : 24'd0);
            check("d3_ypos", 24'(d3_y), r3_e ? 24'(q3 / HT - VS - VB) : 24'd0);

            de_cnt1  += int'(d1_de);
            req_cnt1 += int'(d1_req);
            de_cnt3  += int'(d3_de);
            req_cnt3 += int'(d3_req);
            if (p == FT - 1) begin
                check("d1_de_per_frame", 24'(de_cnt1), 24'(HD * VD));
                check("d1_req_per_frame", 24'(req_cnt1), 24'(HD * VD));
                check("d3_de_per_frame", 24'(de_cnt3), 24'(HD * VD));
                check("d3_req_per_frame", 24'(req_cnt3), 24'(HD * VD));
            end
            pos = (p + 1) % FT;

            case ($urandom_range(0, 3))
                0:       pixel_in = {8'($urandom), 16'hF81F};
                1:       pixel_in = {8'($urandom), 16'h07E0};
                default: pixel_in = 24'($urandom);
            endcase
            solid_rgb = 24'($urandom);
        end
    endtask

    initial begin
        int split;
        #1 rst_n = 1'b0;
        #2 check_reset_values("por_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_values("por_hold");
        rst_n = 1'b1;
        pos   = 0;

        // Pass-through frame; switch to solid mid-frame, takes effect next frame.
        step(100);
        fmt_sel = 2'd3;
        step(180);
        step(140);
        fmt_sel = 2'd0;
        step(140);
        step(140);
        fmt_sel = 2'd2;
        step(140);
        step(140);
        fmt_sel = 2'd1;
        step(20);

        // Counter now sits at h=20, v=5: reset asynchronously between edges.
        #3 rst_n = 1'b0;
        #1 check_reset_values("mid_async");
        @(posedge clk); #1;
        check_reset_values("mid_hold");
        rst_n = 1'b1;
        pos   = 0;

        for (int f = 0; f < 3; f++) begin
            split   = $urandom_range(1, FT - 1);
            fmt_sel = 2'($urandom);
            step(split);
            fmt_sel = 2'($urandom);
            step(FT - split);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameters: H_SYNC, default 44, hsync width in pixels.
REQ-002 SHALL have parameters: H_BACK 148, H_DISP 1920, H_FRONT 88, V_SYNC 5, V_BACK 36, V_DISP 1080, V_FRONT 4; all are counts ≥1.
REQ-003 SHALL have parameters: REQ_LEAD, default 1, range 1..4, number of cycles data_req leads video_de.
REQ-004 SHALL have parameters: SYNC_POL, default 1, active level of video_hs and video_vs.
REQ-005 SHALL have ports: pixel_clk  in  1  pixel clock; all logic on its rising edge.
REQ-006 SHALL have ports: sys_rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: fmt_sel  in  2  0=RGB565 expand, 1=RGB888 pass, 2=colour bars, 3=solid colour.
REQ-008 SHALL have ports: pixel_in  in  24  source pixel; RGB565 occupies [15:0].
REQ-009 SHALL have ports: solid_rgb  in  24  colour used in mode 3.
REQ-010 SHALL have ports: data_req  out  1  pixel fetch request.
REQ-011 SHALL have ports: pixel_xpos  out  11  column being requested.
REQ-012 SHALL have ports: pixel_ypos  out  11  row being requested.
REQ-013 SHALL have ports: video_hs, video_vs, video_de  out  1 each  timing outputs.
REQ-014 SHALL have ports: video_rgb  out  24  output pixel.
REQ-015 SHALL have ports: frame_start  out  1  one-cycle pulse at frame start.

Function
REQ-016 SHALL keep h_cnt in 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters; it wraps to 0.
REQ-017 SHALL increment v_cnt in 0..V_TOTAL-1 only on an h_cnt wrap; v_cnt wraps to 0 on an h_cnt wrap when v_cnt=V_TOTAL-1.
REQ-018 SHALL drive video_hs and video_vs at SYNC_POL for h_cnt<H_SYNC and v_cnt<V_SYNC respectively, one cycle after the counter value (registered decode).
REQ-019 SHALL drive video_de high one cycle after every counter state where both conditions hold: H_SYNC+H_BACK ≤ h_cnt < H_SYNC+H_BACK+H_DISP, and the corresponding V condition.
REQ-020 SHALL assert data_req, registered, in the active-video rows only, exactly REQ_LEAD cycles before each video_de cycle; it SHALL have the same length as video_de, exactly H_DISP cycles per line.
REQ-021 SHALL drive pixel_xpos 0..H_DISP-1 and pixel_ypos 0..V_DISP-1 as the coordinates of the pixel requested while data_req is high; both SHALL be 0 otherwise.
REQ-022 SHALL treat the source as returning the pixel for a request REQ_LEAD-1 cycles later; video_rgb in a video_de cycle SHALL equal the converted pixel_in from the previous cycle.
REQ-023 SHALL, in mode 0, output {p[15:11],3'b000,p[10:5],2'b00,p[4:0],3'b000}.
REQ-024 SHALL, in mode 1, output pixel_in unchanged.
REQ-025 SHALL, in mode 2, output 8 vertical bars of width H_DISP/8 in the order white, yellow, cyan, green, magenta, red, blue, black, indexed by output column; remainder columns SHALL be black.
REQ-026 SHALL, in mode 3, output solid_rgb.
REQ-027 SHALL ignore pixel_in in modes 2 and 3, while data_req still toggles normally.
REQ-028 SHALL drive video_rgb to 24'h000000 whenever video_de is low.
REQ-029 SHALL latch fmt_sel only when h_cnt=0 and v_cnt=0; a mid-frame change SHALL take effect at the next frame.
REQ-030 SHALL pulse frame_start high for exactly one cycle, coincident with the first video_vs active cycle of each frame.
REQ-031 SHALL use counter widths of at least 12 bits; no intermediate sum SHALL overflow for totals ≤4095.

Reset
REQ-032 SHALL, while sys_rst_n=0, clear h_cnt, v_cnt and the latched mode; data_req, video_de and frame_start SHALL be 0, video_rgb and both positions 0, and video_hs/video_vs at ~SYNC_POL.
REQ-033 SHALL, on release of reset, produce hsync and vsync active plus frame_start on the first clock edge; timing SHALL restart cleanly from h_cnt=0, v_cnt=0 if reset is applied mid-frame.

Verification
Parameters for all scenarios: H=4/4/16/4 (H_TOTAL 28), V=2/2/4/2 (V_TOTAL 10), REQ_LEAD=1, SYNC_POL=1.
REQ-034 SHALL cover: reset release, mode 1 -> hs high for cycles 1-4 of every 28; vs high for the first 56 cycles; frame period 280; frame_start pulses at cycles 1, 281, 561.
REQ-035 SHALL cover: count per frame -> 64 de cycles in 4 rows of 16; data_req rises exactly 1 cycle before de; pixel_xpos runs 0..15 and pixel_ypos runs 0..3.
REQ-036 SHALL cover: mode 0 with pixel_in=16'hF81F -> video_rgb=24'hF800F8; with 16'h07E0 -> 24'h00FC00.
REQ-037 SHALL cover: mode 2 -> columns 0-1 give FFFFFF, 2-3 FFFF00, ..., 14-15 000000; video_rgb=0 outside de.
REQ-038 SHALL cover: fmt_sel switched 1->3 mid-frame -> the rest of that frame stays in pass-through; the next frame outputs solid_rgb.
REQ-039 SHALL cover: sys_rst_n pulsed low at h_cnt=20, v_cnt=5 -> outputs go to reset values immediately, without waiting for a clock; the next frame_start occurs 1 cycle after release.
REQ-040 SHALL cover: REQ_LEAD=3 rebuild -> data_req leads de by 3 cycles; the de count is unchanged.
